// File: rtl/selector_modo.sv
// rtl/selector_modo.sv - MODE button synchronizer, debouncer and 3-state cyclic mode counter
module selector_modo #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       boton,
  output logic [1:0] modo,
  output logic       cambio_modo
);

  localparam logic [1:0] MODO0 = 2'd0;
  localparam logic [1:0] MODO1 = 2'd1;
  localparam logic [1:0] MODO2 = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             db;
  logic             db_d;
  logic [CNT_W-1:0] cnt;
  logic             press;

  assign press = db & ~db_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      db          <= 1'b0;
      db_d        <= 1'b0;
      cnt         <= '0;
      modo        <= MODO0;
      cambio_modo <= 1'b0;
    end else begin
      s1   <= boton;
      s2   <= s1;
      db_d <= db;

      // any cycle agreeing with db restarts the stability count
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      cambio_modo <= press;

      case (modo)
        MODO0:   if (press) modo <= MODO1;
        MODO1:   if (press) modo <= MODO2;
        MODO2:   if (press) modo <= MODO0;
        default: modo <= MODO0;
      endcase
    end
  end

endmodule

// File: tb/tb_selector_modo.sv
// tb/tb_selector_modo.sv - randomized and directed bench for selector_modo against a window-based model
module tb_selector_modo;

  localparam int DC = 4;

  logic       clk;
  logic       reset;
  logic       boton;
  logic [1:0] modo;
  logic       cambio_modo;

  int n_tests;
  int n_fail;
  int dut_pulses;

  // reference model state
  bit m_s1, m_s2, m_db, m_db_d, m_pulse;
  int m_modo;
  bit hist[$];

  selector_modo #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .boton       (boton),
    .modo        (modo),
    .cambio_modo (cambio_modo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // db flips once the last DC synchronized samples have all disagreed with it
  task automatic model_edge(input bit b, input bit r);
    bit press;
    bit all_diff;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_db_d = 0; m_pulse = 0; m_modo = 0;
      hist.delete();
      return;
    end
    press   = m_db && !m_db_d;
    m_pulse = press;
    if (press) m_modo = (m_modo + 1) % 3;
    m_db_d = m_db;
    hist.push_back(m_s2 != m_db);
    if (hist.size() > DC) void'(hist.pop_front());
    all_diff = (hist.size() == DC);
    foreach (hist[i]) if (!hist[i]) all_diff = 0;
    if (all_diff) begin
      m_db = !m_db;
      hist.delete();
    end
    m_s2 = m_s1;
    m_s1 = b;
  endtask

  task automatic step(input bit b, input bit r);
    @(negedge clk);
    boton = b;
    reset = r;
    @(posedge clk);
    model_edge(b, r);
    #1;
    chk("modo", int'(modo), m_modo);
    chk("cambio_modo", int'(cambio_modo), int'(m_pulse));
    if (cambio_modo) dut_pulses++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(i[0], 1'b1);
    step(1'b0, 1'b0);
    chk("post_reset_modo", int'(modo), 0);
    chk("post_reset_pulse", int'(cambio_modo), 0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    int lvl;
    int len;
    n_tests    = 0;
    n_fail     = 0;
    boton      = 1'b0;
    reset      = 1'b1;
    m_modo     = 0;

    do_reset(3);

    // single clean press with fixed latency, then long hold
    for (int e = 1; e <= 58; e++) begin
      step(1'b1, 1'b0);
      if (e == 6) chk("lat6_modo", int'(modo), 0);
      if (e == 7) begin
        chk("lat7_modo", int'(modo), 1);
        chk("lat7_pulse", int'(cambio_modo), 1);
      end
      if (e == 8) chk("lat8_pulse", int'(cambio_modo), 0);
    end
    chk("hold_modo", int'(modo), 1);

    // wrap-around over four presses
    do_reset(3);
    dut_pulses = 0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    end
    chk("wrap_pulses", dut_pulses, 4);
    chk("wrap_modo", int'(modo), 1);

    // bounce then steady high yields one advance
    do_reset(3);
    dut_pulses = 0;
    begin
      bit pat [8] = '{1, 1, 1, 0, 1, 1, 0, 1};
      foreach (pat[i]) step(pat[i], 1'b0);
    end
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    chk("bounce_pulses", dut_pulses, 1);
    chk("bounce_modo", int'(modo), 1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);

    // isolated 3-cycle glitch is rejected
    dut_pulses = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
    chk("glitch_pulses", dut_pulses, 0);
    chk("glitch_modo", int'(modo), 1);

    // reset mid-debounce with button held
    do_reset(3);
    for (int e = 1; e <= 3; e++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("midrst_modo", int'(modo), 0);
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b0);
      if (k == 6) chk("midrst_k6", int'(modo), 0);
      if (k == 7) chk("midrst_k7", int'(modo), 1);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);

    // randomized runs of random level and length, occasional reset
    for (int r = 0; r < 600; r++) begin
      lvl = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      for (int i = 0; i < len; i++) step(lvl[0], ($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
